// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types, funct3 encodings and access-size helpers for the RV32I core
package cpu_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {OP_ALU, OP_LOAD, OP_STORE, OP_JAL} lsu_op_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_t;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;
  // 0 = byte, 1 = half, 2 = word; unused encodings fall back to word
  function automatic logic [1:0] access_size(input lsu_op_t op, input logic [2:0] f3);
    if (op == OP_LOAD)
      return (f3 == F3_LB || f3 == F3_LBU) ? 2'd0 : (f3 == F3_LH || f3 == F3_LHU) ? 2'd1 : 2'd2;
    return f3 == F3_SB ? 2'd0 : f3 == F3_SH ? 2'd1 : 2'd2;
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return size == 2'd1 ? a[0] : size == 2'd2 ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half out of a word and sign- or zero-extends it
module load_align
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // Lane selection by low address bits, then extension by funct3
  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
           funct3 == F3_LBU ? {24'b0, b} :
           funct3 == F3_LH  ? {{16{h[15]}}, h} :
           funct3 == F3_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/lsu_writeback.sv
// lsu_writeback: memory/writeback stage feeding the register-file write port
module lsu_writeback
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [1:0]      ex_op,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [XLEN-1:0] ex_pc_plus4,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_wdata,
  output logic            misalign,
  output logic            bus_err,
  output logic [XLEN-1:0] fault_addr
);
  lsu_state_t      state, state_next;
  lsu_op_t         op_in, op_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] addr_q, wdata_q, ld_data, lane_wdata;
  logic [3:0]      be_q, lane_be;
  logic [7:0]      cnt;
  logic [1:0]      sz;
  logic            accept, is_mem, mis, expire;

  load_align u_align (.rdata(mem_rdata), .addr(addr_q[1:0]), .funct3(f3_q), .data(ld_data));

  assign ex_ready  = state == IDLE && !reset;
  assign mem_req   = state == REQ && !reset;
  assign mem_we    = mem_req && op_q == OP_STORE;
  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  // Decode the offered instruction: access size, alignment and store byte lanes
  always_comb begin
    op_in = lsu_op_t'(ex_op);
    accept = ex_valid && ex_ready;
    is_mem = op_in == OP_LOAD || op_in == OP_STORE;
    sz = access_size(op_in, ex_funct3);
    mis = is_mem && misaligned(sz, ex_alu_result[1:0]);
    lane_wdata = sz == 2'd0 ? {4{ex_store_data[7:0]}} : sz == 2'd1 ? {2{ex_store_data[15:0]}} : ex_store_data;
    lane_be = sz == 2'd0 ? 4'b0001 << ex_alu_result[1:0] : sz == 2'd1 ? 4'b0011 << ex_alu_result[1:0] : 4'b1111;
    expire = cnt == 8'(TIMEOUT - 1);
  end

  // Next state: a grant or load data arriving on the expiry cycle still wins
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept && is_mem && !mis ? REQ : IDLE;
      REQ:     state_next = mem_gnt ? (op_q == OP_STORE ? IDLE : WAIT) : expire ? IDLE : REQ;
      WAIT:    state_next = mem_rvalid || expire ? IDLE : WAIT;
      default: state_next = IDLE;
    endcase
  end

  // State, access latch, timeout counter and registered writeback/fault outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= OP_ALU;
      f3_q <= '0;
      rd_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      wb_we <= 1'b0;
      wb_rd <= '0;
      wb_wdata <= '0;
      misalign <= 1'b0;
      bus_err <= 1'b0;
      fault_addr <= '0;
    end else begin
      state <= state_next;
      cnt <= (state_next == state && state != IDLE) ? cnt + 8'd1 : 8'd0;
      wb_we <= 1'b0;
      misalign <= 1'b0;
      bus_err <= 1'b0;
      if (accept) begin
        if (!is_mem) begin
          wb_we <= |ex_rd;
          wb_rd <= ex_rd;
          wb_wdata <= op_in == OP_JAL ? ex_pc_plus4 : ex_alu_result;
        end else if (mis) begin
          misalign <= 1'b1;
          fault_addr <= ex_alu_result;
        end else begin
          op_q <= op_in;
          f3_q <= ex_funct3;
          rd_q <= ex_rd;
          addr_q <= ex_alu_result;
          wdata_q <= lane_wdata;
          be_q <= lane_be;
        end
      end
      if (state == WAIT && mem_rvalid) begin
        wb_we <= |rd_q;
        wb_rd <= rd_q;
        wb_wdata <= ld_data;
      end
      if (expire && ((state == REQ && !mem_gnt) || (state == WAIT && !mem_rvalid))) begin
        bus_err <= 1'b1;
        fault_addr <= addr_q;
      end
    end
  end
endmodule

// File: tb/tb_lsu_writeback.sv
// tb_lsu_writeback: directed scoreboard bench for the memory/writeback stage
module tb_lsu_writeback;
  import cpu_pkg::*;
  logic        clk = 1'b0;
  logic        reset, ex_valid, ex_ready;
  logic [1:0]  ex_op;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, ex_store_data, ex_pc_plus4;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_we, misalign, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata, fault_addr;

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_t;
  wb_t sb_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  lsu_writeback #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_pc_plus4(ex_pc_plus4), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_wdata(wb_wdata), .misalign(misalign), .bus_err(bus_err),
    .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input lsu_op_t op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4);
    ex_valid = 1'b1;
    ex_op = op;
    ex_funct3 = f3;
    ex_rd = rd;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_pc_plus4 = pc4;
  endtask

  // Scoreboard: every register-file write must match the oldest expected write
  always @(negedge clk) begin
    if (!reset && wb_we) begin
      n_chk++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL wb_unexpected: observed write rd %0d data %h expected none", wb_rd, wb_wdata);
      end
      if (sb_q.size() != 0) begin
        wb_t e;
        e = sb_q.pop_front();
        chk("sb_wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("sb_wb_wdata", wb_wdata, e.data);
      end
    end
  end

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp, input int gd, input int rvd);
    drive(OP_LOAD, f3, rd, addr, 32'h0, 32'h0);
    sb_q.push_back(wb_t'{rd, exp});
    tick();
    ex_valid = 1'b0;
    repeat (gd) begin
      chk("ld_ready_req", 32'(ex_ready), 0);
      tick();
    end
    chk("ld_mem_req", 32'(mem_req), 1);
    chk("ld_mem_we", 32'(mem_we), 0);
    chk("ld_mem_addr", mem_addr, {addr[31:2], 2'b00});
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("ld_no_bus_err", 32'(bus_err), 0);
    repeat (rvd - 1) begin
      chk("ld_wait_req", 32'(mem_req), 0);
      tick();
    end
    chk("ld_ready_wait", 32'(ex_ready), 0);
    mem_rvalid = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0;
    chk("ld_wb_we", 32'(wb_we), 32'(rd != 0));
    chk("ld_wb_wdata", wb_wdata, exp);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [3:0] be, input logic [31:0] wd, input int gd);
    drive(OP_STORE, f3, 5'd9, addr, sd, 32'h0);
    tick();
    ex_valid = 1'b0;
    repeat (gd + 1) begin
      chk("st_mem_req", 32'(mem_req), 1);
      chk("st_mem_we", 32'(mem_we), 1);
      chk("st_mem_addr", mem_addr, {addr[31:2], 2'b00});
      chk("st_mem_be", 32'(mem_be), 32'(be));
      chk("st_mem_wdata", mem_wdata, wd);
      chk("st_ready", 32'(ex_ready), 0);
      if (gd == 0) mem_gnt = 1'b1;
      gd--;
      tick();
    end
    mem_gnt = 1'b0;
    chk("st_req_drop", 32'(mem_req), 0);
    chk("st_ready_back", 32'(ex_ready), 1);
    chk("st_wb_we", 32'(wb_we), 0);
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 1'b0;
    ex_op = 2'd0;
    ex_funct3 = 3'd0;
    ex_rd = 5'd0;
    ex_alu_result = 32'h0;
    ex_store_data = 32'h0;
    ex_pc_plus4 = 32'h0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_ex_ready", 32'(ex_ready), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_wb_we", 32'(wb_we), 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    chk("rst_fault_addr", fault_addr, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ex_ready), 1);
    // Back-to-back ALU / ALU rd=0 / JAL
    drive(OP_ALU, 3'd0, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0);
    sb_q.push_back(wb_t'{5'd5, 32'hDEADBEEF});
    tick();
    chk("alu_wb_we", 32'(wb_we), 1);
    chk("alu_wb_rd", 32'(wb_rd), 5);
    chk("alu_wb_wdata", wb_wdata, 32'hDEADBEEF);
    drive(OP_ALU, 3'd0, 5'd0, 32'h12345678, 32'h0, 32'h0);
    tick();
    chk("alu_x0_we", 32'(wb_we), 0);
    chk("alu_x0_wdata", wb_wdata, 32'h12345678);
    drive(OP_JAL, 3'd0, 5'd1, 32'h5555, 32'h0, 32'h1004);
    sb_q.push_back(wb_t'{5'd1, 32'h1004});
    tick();
    chk("jal_wb_we", 32'(wb_we), 1);
    chk("jal_wb_wdata", wb_wdata, 32'h1004);
    ex_valid = 1'b0;
    tick();
    chk("pulse_wb_we", 32'(wb_we), 0);
    // Loads: extension and lane selection
    do_load(5'd7, F3_LB, 32'h103, 32'h80FF1234, 32'hFFFFFF80, 1, 2);
    do_load(5'd7, F3_LBU, 32'h103, 32'h80FF1234, 32'h00000080, 0, 1);
    do_load(5'd2, F3_LH, 32'h102, 32'h80FF1234, 32'hFFFF80FF, 0, 1);
    do_load(5'd2, F3_LHU, 32'h100, 32'h80FF1234, 32'h00001234, 0, 2);
    do_load(5'd3, F3_LW, 32'h104, 32'h80FF1234, 32'h80FF1234, 0, 1);
    do_load(5'd0, F3_LB, 32'h101, 32'h0000C300, 32'hFFFFFFC3, 0, 1);
    sb_q.pop_back();
    // Stores: lanes held until grant
    do_store(F3_SH, 32'h202, 32'h0000ABCD, 4'b1100, 32'hABCDABCD, 2);
    do_store(F3_SB, 32'h301, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 0);
    do_store(F3_SW, 32'h304, 32'h13579BDF, 4'b1111, 32'h13579BDF, 1);
    // Misaligned word load, then immediate next instruction
    drive(OP_LOAD, F3_LW, 5'd3, 32'h101, 32'h0, 32'h0);
    tick();
    chk("mis_pulse", 32'(misalign), 1);
    chk("mis_fault_addr", fault_addr, 32'h101);
    chk("mis_mem_req", 32'(mem_req), 0);
    chk("mis_wb_we", 32'(wb_we), 0);
    chk("mis_ready", 32'(ex_ready), 1);
    drive(OP_ALU, 3'd0, 5'd4, 32'h44, 32'h0, 32'h0);
    sb_q.push_back(wb_t'{5'd4, 32'h44});
    tick();
    ex_valid = 1'b0;
    chk("mis_pulse_end", 32'(misalign), 0);
    chk("mis_next_we", 32'(wb_we), 1);
    // Grant timeout: four cycles in REQ
    drive(OP_LOAD, F3_LW, 5'd6, 32'h400, 32'h0, 32'h0);
    tick();
    ex_valid = 1'b0;
    repeat (4) begin
      chk("to_req_held", 32'(mem_req), 1);
      chk("to_no_err_yet", 32'(bus_err), 0);
      tick();
    end
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_fault_addr", fault_addr, 32'h400);
    chk("to_wb_we", 32'(wb_we), 0);
    chk("to_ready", 32'(ex_ready), 1);
    tick();
    chk("to_err_pulse_end", 32'(bus_err), 0);
    // Grant on the expiry cycle wins
    do_load(5'd6, F3_LW, 32'h500, 32'h11223344, 32'h11223344, 3, 1);
    // Reset while waiting for load data, then a stale rvalid
    drive(OP_LOAD, F3_LW, 5'd8, 32'h700, 32'h0, 32'h0);
    tick();
    ex_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(ex_ready), 0);
    chk("mid_rst_fault", fault_addr, 0);
    reset = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_rvalid = 1'b0;
    chk("stale_wb_we", 32'(wb_we), 0);
    chk("stale_wb_wdata", wb_wdata, 0);
    chk("stale_mem_req", 32'(mem_req), 0);
    chk("stale_ready", 32'(ex_ready), 1);
    tick();
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_writeback.md
Name: lsu_writeback

Overview:
Memory/writeback stage of the single-issue RV32I core. It sits directly upstream of the register file.
- Accepts one executed instruction at a time.
- Performs the load/store handshake with data memory.
- Aligns and extends load data.
- Drives the register file's rd/wdata/we write port through a registered output.
- Back-pressures execute while a memory access is in flight. Flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 16, max cycles to wait for mem_gnt or mem_rvalid before aborting with bus_err (range 2..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
ex_valid  in  1  execute presents an instruction
ex_ready  out  1  stage can accept; transfer when ex_valid && ex_ready
ex_op  in  2  lsu_op_t: OP_ALU, OP_LOAD, OP_STORE, OP_JAL
ex_funct3  in  3  RV32I load/store width/sign encoding
ex_rd  in  5  destination register
ex_alu_result  in  32  ALU result / effective address
ex_store_data  in  32  rs2 value for stores
ex_pc_plus4  in  32  link value for JAL/JALR
mem_req  out  1  data-memory request
mem_we  out  1  1 = store
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  32  store data shifted into byte lanes
mem_be  out  4  byte enables
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  load data valid
mem_rdata  in  32  load data word
wb_we  out  1  register-file write enable
wb_rd  out  5  register-file destination
wb_wdata  out  32  register-file write data
misalign  out  1  one-cycle pulse: misaligned access dropped
bus_err  out  1  one-cycle pulse: memory timeout
fault_addr  out  32  address of last misalign/bus_err, held until next fault

Behaviour:
- Reset: state IDLE; all outputs 0 (ex_ready=0 during reset, 1 in first cycle after); timeout counter 0. Reset mid-access aborts the access; the stage ignores later mem_gnt/mem_rvalid from that access.
- FSM states: IDLE, REQ, WAIT.
- IDLE, ex_ready=1. On accept:
  - OP_ALU: wb_we/wb_rd/wb_wdata=alu_result registered, visible next cycle (latency 1). Stay in IDLE.
  - OP_JAL: same, with wdata=pc_plus4.
  - OP_LOAD/OP_STORE aligned: latch op, funct3, rd, addr, lanes. Go to REQ. mem_req rises next cycle.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No memory request, no writeback.
  - misalign=1 and fault_addr=addr next cycle.
  - Stay in IDLE.
- REQ: ex_ready=0; mem_req=1 with addr/we/wdata/be held stable until mem_gnt.
  - Store: on gnt go to IDLE.
  - Load: on gnt go to WAIT.
- WAIT: ex_ready=0, mem_req=0.
  - On mem_rvalid, select byte/half via addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Register to wb_* next cycle; go to IDLE.
  - mem_rvalid in the same cycle as mem_gnt is not allowed; the minimum load latency is gnt then rvalid one or more cycles later.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata=byte replicated ×4.
  - SH: be=0011<<addr[1:0], wdata=half replicated ×2.
  - SW: be=1111.
- Timeout: counter clears on entering REQ/WAIT and increments each cycle there.
  - When it reaches TIMEOUT-1 without gnt/rvalid: bus_err pulse next cycle, fault_addr=addr, no writeback, return to IDLE.
  - gnt/rvalid arriving in the same cycle as expiry wins; no error.
- wb_we is a 1-cycle pulse per retiring instruction. wb_we is forced 0 when rd==0, but wb_rd/wb_wdata still update.
- Stores never assert wb_we.
- Unused funct3 encodings (loads 3,6,7; stores 3..7): treated as word access.
- Throughput: 1 instr/cycle for ALU/JAL. Loads take at least 3 cycles in the stage; stores at least 2.

Decomposition:
- Package cpu_pkg:
  - lsu_op_t enum.
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - lsu_state_t.
  - XLEN=32.
- Sub-module load_align (combinational).
  - Inputs: rdata, addr[1:0], funct3.
  - Output: extended 32-bit value.
  - Reused later by the instruction-fetch unit for compressed-instruction extraction.
- Store-lane generation stays inline.

Test Plan:
1. ALU op rd=5, alu_result=0xDEADBEEF → next cycle wb_we=1, wb_rd=5, wb_wdata=0xDEADBEEF. ALU op with rd=0 → wb_we=0.
2. LB addr=0x103, mem_rdata=0x80FF_1234, gnt after 1 cycle, rvalid 2 cycles later → wb_wdata=0xFFFFFF80. LBU at the same address → 0x00000080. ex_ready=0 throughout.
3. SH addr=0x202, data=0x0000ABCD → mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, held until gnt. wb_we stays 0.
4. LW addr=0x101 → no mem_req, misalign pulse, fault_addr=0x101, wb_we=0. Next instruction accepted the following cycle.
5. TIMEOUT=4, LW with gnt never asserted → bus_err pulse after 4 cycles in REQ, fault_addr latched, returns to IDLE. Repeat with gnt in the 4th cycle → no bus_err.
6. Assert reset in WAIT, then drive a stale rvalid → no wb_we, state IDLE, all outputs 0.
